// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs (ALU, D-cache) drained one per cycle, round-robin on ties.
// Define CDB_BYPASS_EN to let a result skip its empty FIFO and load the CDB register directly.
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 6,   // ROB_DEPTH_BITS
  parameter int DATA_W     = 32   // DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              dc_valid,
  input  logic [TAG_W-1:0]  dc_tag,
  input  logic [DATA_W-1:0] dc_data,
  output logic              alu_stall,
  output logic              dc_stall,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = TAG_W + DATA_W;

  typedef enum logic { SRC_ALU = 1'b0, SRC_DC = 1'b1 } src_e;

  // Index 0 is the ALU source, index 1 the D-cache source.
  logic [EW-1:0]     mem_q    [2][FIFO_DEPTH];
  logic [PW-1:0]     wr_q     [2];
  logic [PW-1:0]     wr_d     [2];
  logic [PW-1:0]     rd_q     [2];
  logic [PW-1:0]     rd_d     [2];
  logic [CW-1:0]     cnt_q    [2];
  logic [CW-1:0]     cnt_d    [2];
  logic [EW-1:0]     in_entry [2];

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              ovf_q, ovf_d;
  src_e              last_q, last_d;

  logic [1:0]        in_valid, empty, full, cand, grant, byp, deq, enq;
  logic              sel;
  logic [EW-1:0]     win_entry;

  assign in_valid    = {dc_valid, alu_valid};
  assign in_entry[0] = {alu_tag, alu_result};
  assign in_entry[1] = {dc_tag, dc_data};

  always_comb begin
    empty = '0;
    full  = '0;
    cand  = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      empty[s] = (cnt_q[s] == '0);
      full[s]  = (cnt_q[s] == CW'(FIFO_DEPTH));
`ifdef CDB_BYPASS_EN
      cand[s]  = !empty[s] || in_valid[s];
`else
      cand[s]  = !empty[s];
`endif
    end
  end

  // A tie goes to the source that did not win the previous grant.
  always_comb begin
    grant = '0;
    if (!flush) begin
      if (cand[0] && cand[1]) begin
        if (last_q == SRC_ALU) grant[1] = 1'b1;
        else                   grant[0] = 1'b1;
      end else begin
        grant = cand;
      end
    end
  end

  always_comb begin
    byp = '0;
    deq = '0;
    enq = '0;
    for (int unsigned s = 0; s < 2; s++) begin
`ifdef CDB_BYPASS_EN
      byp[s] = grant[s] && empty[s];
`endif
      deq[s] = grant[s] && !empty[s];
      enq[s] = in_valid[s] && !flush && !full[s] && !byp[s];
    end
  end

  assign sel       = grant[1];
  assign win_entry = byp[sel] ? in_entry[sel] : mem_q[sel][rd_q[sel]];

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    ovf_d       = ovf_q;
    last_d      = last_q;
    for (int unsigned s = 0; s < 2; s++) begin
      wr_d[s]  = wr_q[s];
      rd_d[s]  = rd_q[s];
      cnt_d[s] = cnt_q[s];
      if (flush) begin
        wr_d[s]  = '0;
        rd_d[s]  = '0;
        cnt_d[s] = '0;
      end else begin
        if (enq[s]) wr_d[s] = wr_q[s] + PW'(1);
        if (deq[s]) rd_d[s] = rd_q[s] + PW'(1);
        cnt_d[s] = cnt_q[s] + CW'(enq[s]) - CW'(deq[s]);
        if (in_valid[s] && full[s]) ovf_d = 1'b1;
      end
    end
    if (|grant) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = win_entry[EW-1:DATA_W];
      cdb_data_d  = win_entry[DATA_W-1:0];
      last_d      = src_e'(sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < 2; s++) begin
        wr_q[s]  <= '0;
        rd_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      ovf_q       <= 1'b0;
      last_q      <= SRC_ALU;
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        wr_q[s]  <= wr_d[s];
        rd_q[s]  <= rd_d[s];
        cnt_q[s] <= cnt_d[s];
      end
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (enq[s]) mem_q[s][wr_q[s]] <= in_entry[s];
    end
  end

  // One slot stays free so a result already in flight when stall rises still fits.
  assign alu_stall = (cnt_q[0] >= CW'(FIFO_DEPTH - 1));
  assign dc_stall  = (cnt_q[1] >= CW'(FIFO_DEPTH - 1));
  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model predicts each broadcast and its cycle.
module tb_cdb_arbiter;
  localparam int D  = 4;
  localparam int TW = 6;
  localparam int DW = 32;

  logic          clk, rst, flush;
  logic          alu_valid, dc_valid;
  logic [TW-1:0] alu_tag, dc_tag;
  logic [DW-1:0] alu_result, dc_data;
  logic          alu_stall, dc_stall, cdb_valid, overflow;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;

  cdb_arbiter #(.FIFO_DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_result(alu_result),
    .dc_valid(dc_valid), .dc_tag(dc_tag), .dc_data(dc_data),
    .alu_stall(alu_stall), .dc_stall(dc_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; } ent_t;
  typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; int cyc; } exp_t;

  ent_t          mq_a[$];
  ent_t          mq_d[$];
  exp_t          exp_q[$];
  int            cyc = 0;
  bit            m_last_dc;
  bit            m_ovf;
  logic [TW-1:0] m_ltag;
  logic [DW-1:0] m_ldata;

  // Reference model: each edge, pick a winner from the pre-edge queues, then accept inputs if room.
  always @(posedge clk or posedge rst) begin
    int   na, nd, g;
    ent_t e;
    if (rst) begin
      mq_a.delete(); mq_d.delete(); exp_q.delete();
      m_last_dc = 1'b0; m_ovf = 1'b0; m_ltag = '0; m_ldata = '0;
    end else begin
      cyc++;
      if (flush) begin
        mq_a.delete(); mq_d.delete();
      end else begin
        na = mq_a.size(); nd = mq_d.size(); g = -1;
        if (na > 0 && nd > 0) g = m_last_dc ? 0 : 1;
        else if (na > 0)      g = 0;
        else if (nd > 0)      g = 1;
        if (g >= 0) begin
          e = (g == 0) ? mq_a.pop_front() : mq_d.pop_front();
          m_last_dc = (g == 1);
          m_ltag = e.tag; m_ldata = e.data;
          exp_q.push_back('{tag: e.tag, data: e.data, cyc: cyc});
        end
        if (alu_valid) begin
          if (na >= D) m_ovf = 1'b1;
          else mq_a.push_back('{tag: alu_tag, data: alu_result});
        end
        if (dc_valid) begin
          if (nd >= D) m_ovf = 1'b1;
          else mq_d.push_back('{tag: dc_tag, data: dc_data});
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t ex;
    if (!rst) begin
      if (cdb_valid) begin
        if (exp_q.size() == 0) check("cdb_unexpected", cdb_valid, 0);
        else begin
          ex = exp_q.pop_front();
          check("cdb_tag", cdb_tag, ex.tag);
          check("cdb_data", cdb_data, ex.data);
          check("cdb_cycle", cyc, ex.cyc);
        end
      end else begin
        check("hold_tag", cdb_tag, m_ltag);
        check("hold_data", cdb_data, m_ldata);
        if (exp_q.size() > 0) begin
          ex = exp_q.pop_front();
          check("cdb_missing", cdb_valid, 1);
        end
      end
      check("alu_stall", alu_stall, mq_a.size() >= D - 1);
      check("dc_stall", dc_stall, mq_d.size() >= D - 1);
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic drive(input bit av, input int at, input int ad,
                       input bit dv, input int dt, input int dd, input bit fl);
    @(negedge clk);
    alu_valid = av; alu_tag = TW'(at); alu_result = DW'(ad);
    dc_valid  = dv; dc_tag  = TW'(dt); dc_data   = DW'(dd);
    flush = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_tag", cdb_tag, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stalls", {alu_stall, dc_stall}, 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_tag = '0; alu_result = '0;
    dc_valid = 1'b0; dc_tag = '0; dc_data = '0;
    repeat (2) @(negedge clk);
    check("reset_cdb_valid", cdb_valid, 0);
    check("reset_cdb_tag", cdb_tag, 0);
    check("reset_stalls", {alu_stall, dc_stall}, 0);
    rst = 1'b0;

    drive(1, 5, 'h1234, 0, 0, 0, 0);
    idle(4);
    drive(1, 1, 'hA1, 1, 2, 'hD2, 0);
    idle(4);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 10 + i, 'h100 + i, 0);
    idle(5);
    for (int i = 0; i < 8; i++) drive(1, 16 + i, 'h200 + i, 1, 32 + i, 'h300 + i, 0);
    idle(12);
    check("burst_overflow", overflow, 1);

    for (int i = 0; i < 3; i++) drive(1, 40 + i, $urandom, 1, 48 + i, $urandom, 0);
    drive(1, 44, 'h55, 0, 0, 0, 1);
    idle(5);
    check("flush_stalls", {alu_stall, dc_stall}, 0);

    for (int i = 0; i < 4; i++) drive(1, 50 + i, $urandom, 1, 56 + i, $urandom, 0);
    pulse_reset();
    idle(6);
    drive(1, 3, 'hAA, 1, 4, 'hDD, 0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      bit av, dv, fl;
      av = ($urandom_range(0, 99) < 60) && (!alu_stall || $urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 99) < 60) && (!dc_stall || $urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) pulse_reset();
      drive(av, $urandom, $urandom, dv, $urandom, $urandom, fl);
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
